// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// Receives PS/2 device-to-host frames and queues the received bytes in a
// first-word fall-through FIFO. A frame is a start bit (0), 8 data bits
// sent LSB first, an odd parity bit and a stop bit (1). Data is sampled
// on each falling edge of a debounced copy of the PS/2 clock. Frames
// with a bad stop bit, or frames that stall for too long, are discarded
// and counted.
//
// Parameters:
//   FILTER_LEN   consecutive equal ps2c samples needed to move the filtered clock
//   TIMEOUT_CYC  clk cycles without a sampling strobe before a frame is aborted
//   FIFO_DEPTH   receive FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   ps2c, ps2d     PS/2 clock and data lines (asynchronous)
//   rx_ready       consumer accepts the head entry this cycle
//   rx_valid       FIFO non-empty, head entry presented
//   rx_data        head byte (0 when empty)
//   rx_perr        head entry parity-error flag (0 when empty)
//   fifo_count     number of entries held, 0..FIFO_DEPTH
//   overflow       sticky: a received byte was dropped because the FIFO was full
//   frame_err_cnt  saturating count of stop-bit errors and timeouts
//   busy           a frame is in progress
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_ready,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic                          rx_perr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    frame_err_cnt,
    output logic                          busy
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   TO_ONE    = TW'(1);
    localparam logic [AW:0]     DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_next;

    logic            ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic            filt_clk;
    logic [7:0]      filt_cnt;
    logic            strobe;

    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            perr;
    logic [TW-1:0]   to_cnt;
    logic            timeout;
    logic            push_req;
    logic            stop_err;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            pop, full, accept;
    logic [8:0]      head;

    // Two-flop synchronisers; idle-high lines reset to 1 so reset does not
    // look like a falling clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1 <= 1'b1;
            ps2c_s2 <= 1'b1;
            ps2d_s1 <= 1'b1;
            ps2d_s2 <= 1'b1;
        end else begin
            ps2c_s1 <= ps2c;
            ps2c_s2 <= ps2c_s1;
            ps2d_s1 <= ps2d;
            ps2d_s2 <= ps2d_s1;
        end
    end

    // Glitch filter: the filtered clock follows ps2c only after FILTER_LEN
    // consecutive differing samples. The strobe is registered together with
    // the 1->0 change, so it is high in the first cycle filt_clk reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= 8'd0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (ps2c_s2 != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk <= ps2c_s2;
                    filt_cnt <= 8'd0;
                    strobe   <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= 8'd0;
            end
        end
    end

    assign timeout = (state != IDLE) && !strobe && (to_cnt == TO_LAST);

    // Frame FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM: next state. A timeout overrides everything but IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (strobe && !ps2d_s2) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (strobe && bit_idx == 3'd7) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (strobe) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (timeout || strobe) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame FSM: outputs
    always_comb begin
        busy     = (state != IDLE);
        push_req = (state == STOP) && strobe && ps2d_s2;
        stop_err = (state == STOP) && strobe && !ps2d_s2;
    end

    // Receive datapath: shift register, bit index, parity and stall timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            perr    <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state == IDLE || strobe || timeout) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_ONE;
            end
            if (strobe) begin
                case (state)
                    IDLE: begin
                        bit_idx <= 3'd0;
                    end
                    DATA: begin
                        shreg   <= {ps2d_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    PARITY: begin
                        perr <= ~(^shreg ^ ps2d_s2);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_cnt <= 8'd0;
        end else if ((stop_err || timeout) && frame_err_cnt != 8'hFF) begin
            frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end

    // FIFO control. A push into a full FIFO is still accepted when the head
    // is popped in the same cycle; the read happens before the overwrite.
    assign pop    = rx_valid && rx_ready;
    assign full   = (count == DEPTH);
    assign accept = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {perr, shreg};
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? head[7:0] : 8'h00;
    assign rx_perr    = rx_valid ? head[8] : 1'b0;
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
// Self-checking bench for ps2_rx_fifo. Drives PS/2 frames bit by bit and
// keeps a reference model made of a queue of expected {perr, byte}
// entries, an expected frame-error count and an expected overflow flag.
// A monitor pops the model queue whenever the design hands over an entry.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int FIFO_DEPTH  = 16;
    localparam int HP          = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic        rx_ready = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_perr;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  frame_err_cnt;
    logic        busy;

    ps2_rx_fifo #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_perr      (rx_perr),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .frame_err_cnt(frame_err_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] exp_q[$];
    int         exp_ferr = 0;
    logic       exp_ovf = 1'b0;
    int         ready_mode = 1;
    int         valid_cycles = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        bit         exp_push;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Odd parity: an error when data plus parity hold an even number of ones.
    function automatic logic odd_perr(input logic [7:0] d, input logic p);
        return ($countones({d, p}) % 2) == 0;
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // action: 0 nothing, 1 frame delivers val, 2 frame is an error
    task automatic modelUpdate(input int action, input logic [8:0] val);
        if (action == 1) begin
            if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(val);
        end else if (action == 2) begin
            if (exp_ferr < 255) exp_ferr++;
        end
    endtask

    // Sends the first nbits of a frame; with glitch set, each high phase
    // carries a ps2c low pulse one sample too short to pass the filter.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                                 input int nbits, input bit glitch, input int action,
                                 input logic [8:0] val);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                cycles(5);
                ps2c = 1'b0;
                cycles(FILTER_LEN - 1);
                ps2c = 1'b1;
                cycles(HP - 5 - (FILTER_LEN - 1));
            end else begin
                cycles(HP);
            end
            ps2c = 1'b0;
            if (i == 10) modelUpdate(action, val);
            cycles(HP);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cycles(HP);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rx_ready = 1'b0;
                1: rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks every handed-over entry against the model queue and
    // that a stalled head stays put.
    initial begin
        logic       prev_hold;
        logic [8:0] prev_head;
        logic [8:0] e;
        prev_hold = 1'b0;
        prev_head = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (rx_valid) valid_cycles++;
                if (prev_hold) begin
                    checkOutput("hold_valid", rx_valid, 1);
                    checkOutput("hold_head", {rx_perr, rx_data}, prev_head);
                end
                if (rx_valid && rx_ready) begin
                    checkOutput("pop_has_model_entry", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("pop_entry", {rx_perr, rx_data}, e);
                    end
                end
                prev_hold = rx_valid && !rx_ready;
                prev_head = {rx_perr, rx_data};
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        cycles(4);
        reset = 1'b0;
        cycles(1);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_rx_perr", rx_perr, 0);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_err_cnt", frame_err_cnt, 0);
        checkOutput("rst_busy", busy, 0);

        ready_mode = 1;
        for (int i = 0; i < 7; i++) begin
            valid_cycles = 0;
            applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, 11, 1'b0,
                          vecs[i].exp_push ? 1 : 2, {vecs[i].exp_perr, vecs[i].data});
            cycles(20);
            checkOutput($sformatf("vec%0d_valid_cycles", i), valid_cycles, vecs[i].exp_push ? 1 : 0);
            checkOutput($sformatf("vec%0d_frame_err_cnt", i), frame_err_cnt, exp_ferr);
            checkOutput($sformatf("vec%0d_busy", i), busy, 0);
            checkOutput($sformatf("vec%0d_fifo_count", i), fifo_count, 0);
            checkOutput($sformatf("vec%0d_model_drained", i), exp_q.size(), 0);
        end

        // Stop-bit error, then a second frame that stalls after 3 data bits.
        valid_cycles = 0;
        applyStimulus(8'h3C, good_par(8'h3C), 1'b0, 11, 1'b0, 2, 9'h0);
        applyStimulus(8'h81, 1'b1, 1'b1, 4, 1'b0, 0, 9'h0);
        checkOutput("stall_busy_early", busy, 1);
        cycles(TIMEOUT_CYC - 200);
        checkOutput("stall_busy_before_timeout", busy, 1);
        modelUpdate(2, 9'h0);
        cycles(300);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_frame_err_cnt", frame_err_cnt, exp_ferr);
        checkOutput("timeout_no_entries", valid_cycles, 0);
        checkOutput("timeout_fifo_count", fifo_count, 0);

        // Short ps2c pulses while idle with data low must not start a frame.
        valid_cycles = 0;
        ps2d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2c = 1'b0;
            cycles(FILTER_LEN - 1);
            ps2c = 1'b1;
            cycles(12);
            checkOutput($sformatf("idle_glitch%0d_busy", i), busy, 0);
        end
        ps2d = 1'b1;
        cycles(HP);
        applyStimulus(8'h5A, good_par(8'h5A), 1'b1, 11, 1'b1, 1, {1'b0, 8'h5A});
        cycles(20);
        checkOutput("glitch_frame_valid_cycles", valid_cycles, 1);
        checkOutput("glitch_frame_err_cnt", frame_err_cnt, exp_ferr);
        checkOutput("glitch_model_drained", exp_q.size(), 0);

        // Fill past capacity with the consumer stalled, then drain.
        ready_mode = 0;
        cycles(2);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            d = 8'(8'h30 + i);
            applyStimulus(d, good_par(d), 1'b1, 11, 1'b0, 1, {1'b0, d});
        end
        cycles(20);
        checkOutput("full_fifo_count", fifo_count, FIFO_DEPTH);
        checkOutput("full_overflow", overflow, exp_ovf);
        checkOutput("full_rx_valid", rx_valid, 1);
        checkOutput("full_head_data", rx_data, 8'h30);
        checkOutput("full_head_perr", rx_perr, 0);
        ready_mode = 1;
        cycles(40);
        checkOutput("drain_fifo_count", fifo_count, 0);
        checkOutput("drain_model_empty", exp_q.size(), 0);
        checkOutput("drain_overflow_sticky", overflow, 1);

        // Reset in the middle of a frame, then a clean frame.
        applyStimulus(8'hA7, 1'b1, 1'b1, 5, 1'b0, 0, 9'h0);
        checkOutput("midframe_busy", busy, 1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        exp_q.delete();
        exp_ferr = 0;
        exp_ovf = 1'b0;
        checkOutput("midreset_frame_err_cnt", frame_err_cnt, 0);
        checkOutput("midreset_overflow", overflow, 0);
        valid_cycles = 0;
        applyStimulus(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1, {1'b0, 8'hF0});
        cycles(20);
        checkOutput("after_reset_valid_cycles", valid_cycles, 1);
        checkOutput("after_reset_frame_err_cnt", frame_err_cnt, 0);
        checkOutput("after_reset_model_drained", exp_q.size(), 0);

        // Random frames with a randomly stalling consumer.
        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            p = good_par(d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            applyStimulus(d, p, s, 11, 1'b0, s ? 1 : 2, {odd_perr(d, p), d});
            checkOutput($sformatf("rand%0d_frame_err_cnt", i), frame_err_cnt, exp_ferr);
        end
        ready_mode = 1;
        cycles(50);
        checkOutput("rand_model_drained", exp_q.size(), 0);
        checkOutput("rand_fifo_count", fifo_count, 0);
        checkOutput("rand_overflow", overflow, exp_ovf);
        checkOutput("rand_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
